// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
// Contents: FSM state encoding (state_e) and requester port ids (port_e).
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;
  typedef enum logic {PORT_FETCH = 1'b0, PORT_DATA = 1'b1} port_e;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select between the fetch and data ports.
// Ports: f_req/d_req requests, last_grant port granted previously,
//        valid any request present, winner selected port.
// A tie goes to the port not granted last; a constant PORT_FETCH last_grant
// therefore yields fixed data-over-fetch priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic  f_req,
  input  logic  d_req,
  input  port_e last_grant,
  output logic  valid,
  output port_e winner
);
  always_comb begin
    valid  = f_req || d_req;
    winner = (f_req && d_req) ? (last_grant == PORT_DATA ? PORT_FETCH : PORT_DATA)
                              : (d_req ? PORT_DATA : PORT_FETCH);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store ports.
// Ports: clock, reset (async, active-high); fetch port f_req/f_addr -> f_ack/f_rdata;
//        data port d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata; memory side
//        mem_read/mem_write/mem_addr/mem_wdata driven, mem_out read back; busy.
// Build option ROUND_ROBIN_EN: ties alternate via a last_grant register;
// otherwise the data port always wins a tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);
  state_e            state_q, state_d;
  port_e             id_q, id_d, winner, last_grant;
  logic              we_q, we_d, req_any, grab, cap;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

`ifdef ROUND_ROBIN_EN
  port_e last_grant_q, last_grant_d;
  always_comb last_grant_d = grab ? winner : last_grant_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) last_grant_q <= PORT_FETCH;
    else last_grant_q <= last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_FETCH;
`endif

  arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .valid      (req_any),
    .winner     (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      id_q        <= PORT_FETCH;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q == S_IDLE   ? (req_any ? S_SETUP : S_IDLE) :
              state_q == S_SETUP  ? S_ACCESS :
              state_q == S_ACCESS ? S_RESP : S_IDLE;
  end

  // Request fields are captured only on the IDLE grant; later pin changes are ignored.
  always_comb begin
    grab        = state_q == S_IDLE && req_any;
    cap         = state_q == S_ACCESS && !we_q;
    id_d        = grab ? winner : id_q;
    we_d        = grab ? (winner == PORT_DATA && d_we) : we_q;
    mem_addr_d  = grab ? (winner == PORT_DATA ? d_addr : f_addr) : mem_addr_q;
    mem_wdata_d = grab ? (winner == PORT_DATA ? d_wdata : '0) : mem_wdata_q;
    f_rdata_d   = (cap && id_q == PORT_FETCH) ? mem_out : f_rdata_q;
    d_rdata_d   = (cap && id_q == PORT_DATA) ? mem_out : d_rdata_q;
  end

  always_comb begin
    mem_read  = state_q == S_ACCESS && !we_q;
    mem_write = state_q == S_ACCESS && we_q;
    f_ack     = state_q == S_RESP && id_q == PORT_FETCH;
    d_ack     = state_q == S_RESP && id_q == PORT_DATA;
    busy      = state_q != S_IDLE;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench with a memory model and a reference arbiter model.
module tb_mem_port_arbiter;
  logic        clock = 0, reset = 1;
  logic        f_req = 0, d_req = 0, d_we = 0;
  logic [15:0] f_addr = 0, d_addr = 0, d_wdata = 0;
  logic        f_ack, d_ack, mem_read, mem_write, busy;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_out;
  logic        pre_we = 0;
  logic [7:0]  pre_a = 0;
  logic [15:0] pre_d = 0;
  logic [15:0] mem [256];
  int          total = 0, bad = 0;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_out(mem_out), .busy(busy)
  );

  always #5 clock = ~clock;

  assign mem_out = mem[mem_addr[7:0]];
  always @(posedge clock)
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pre_we) mem[pre_a] <= pre_d;

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    @(negedge clock);
    pre_we = 1; pre_a = a; pre_d = v;
    @(negedge clock);
    pre_we = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({busy, f_ack, d_ack, mem_read, mem_write} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, f_ack, d_ack, mem_read, mem_write});
    end
    total++;
    if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, f_rdata, d_rdata});
    end
    reset = 0;
  endtask

  task automatic test_single_fetch();
    preload(8'h03, 16'h1234);
    @(negedge clock);
    f_addr = 16'h0003; f_req = 1;
    @(posedge clock); @(negedge clock);
    f_addr = 16'h00AA;
    total++;
    if ({busy, mem_read, mem_write, f_ack, mem_addr} !== {4'b1000, 16'h0003}) begin
      bad++; $display("FAIL fetch_setup got=%b/%h want=1000/0003", {busy, mem_read, mem_write, f_ack}, mem_addr);
    end
    @(posedge clock); @(negedge clock);
    total++;
    if ({mem_read, mem_write, f_ack, mem_addr} !== {3'b100, 16'h0003}) begin
      bad++; $display("FAIL fetch_access got=%b/%h want=100/0003", {mem_read, mem_write, f_ack}, mem_addr);
    end
    @(posedge clock); @(negedge clock);
    total++;
    if ({f_ack, d_ack, mem_read, f_rdata} !== {3'b100, 16'h1234}) begin
      bad++; $display("FAIL fetch_ack got=%b/%h want=100/1234", {f_ack, d_ack, mem_read}, f_rdata);
    end
    f_req = 0;
    @(posedge clock); @(negedge clock);
    total++;
    if ({f_ack, busy, f_rdata} !== {2'b00, 16'h1234}) begin
      bad++; $display("FAIL fetch_after got=%b/%h want=00/1234", {f_ack, busy}, f_rdata);
    end
  endtask

  task automatic test_store_load();
    int wcnt = 0, ack_at = -1;
    @(negedge clock);
    d_we = 1; d_addr = 16'h0010; d_wdata = 16'hBEEF; d_req = 1;
    @(posedge clock); @(negedge clock);
    total++;
    if ({mem_write, mem_read, mem_addr, mem_wdata} !== {2'b00, 16'h0010, 16'hBEEF}) begin
      bad++; $display("FAIL store_setup got=%b/%h/%h want=00/0010/beef", {mem_write, mem_read}, mem_addr, mem_wdata);
    end
    d_addr = 16'h0055; d_wdata = 16'h0000; d_we = 0;
    for (int i = 2; i <= 8 && ack_at < 0; i++) begin
      @(posedge clock); @(negedge clock);
      if (mem_write === 1'b1) wcnt++;
      if (d_ack === 1'b1) ack_at = i;
    end
    d_req = 0;
    total++;
    if (ack_at != 3 || wcnt != 1) begin
      bad++; $display("FAIL store_timing got ack=%0d writes=%0d want ack=3 writes=1", ack_at, wcnt);
    end
    total++;
    if (d_rdata !== 16'h0000) begin
      bad++; $display("FAIL store_rdata got=%h want=0000", d_rdata);
    end
    @(negedge clock);
    d_we = 0; d_addr = 16'h0010; d_req = 1;
    ack_at = -1;
    for (int i = 1; i <= 8 && ack_at < 0; i++) begin
      @(posedge clock); @(negedge clock);
      if (mem_write === 1'b1) wcnt++;
      if (d_ack === 1'b1) ack_at = i;
    end
    d_req = 0;
    total++;
    if (ack_at != 3 || d_rdata !== 16'hBEEF || wcnt != 1) begin
      bad++; $display("FAIL load_back got ack=%0d data=%h writes=%0d want ack=3 data=beef writes=1", ack_at, d_rdata, wcnt);
    end
  endtask

  task automatic test_tie();
    int fa = -1, da = -1, ef, ed;
`ifdef ROUND_ROBIN_EN
    ef = 3; ed = 7;
`else
    ef = 7; ed = 3;
`endif
    @(negedge clock);
    f_addr = 16'h0003; d_addr = 16'h0010; d_we = 0; f_req = 1; d_req = 1;
    for (int i = 1; i <= 16 && (fa < 0 || da < 0); i++) begin
      @(posedge clock); @(negedge clock);
      if (f_ack === 1'b1 && fa < 0) begin fa = i; f_req = 0; end
      if (d_ack === 1'b1 && da < 0) begin da = i; d_req = 0; end
    end
    f_req = 0; d_req = 0;
    total++;
    if (fa != ef || da != ed) begin
      bad++; $display("FAIL tie_order got f=%0d d=%0d want f=%0d d=%0d", fa, da, ef, ed);
    end
    total++;
    if (f_rdata !== 16'h1234 || d_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL tie_data got f=%h d=%h want f=1234 d=beef", f_rdata, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int idle_run = 0, max_run = 0, fcnt = 0;
    bit hold_f;
`ifdef ROUND_ROBIN_EN
    hold_f = 0;
`else
    hold_f = 1;
`endif
    @(negedge clock);
    d_we = 0; d_addr = 16'h0010; f_addr = 16'h0003; d_req = 1; f_req = hold_f;
    for (int i = 1; i <= 40 && acks.size() < 3; i++) begin
      @(posedge clock); @(negedge clock);
      if (d_ack === 1'b1) acks.push_back(i);
      if (f_ack === 1'b1) fcnt++;
      idle_run = (busy === 1'b1) ? 0 : idle_run + 1;
      if (idle_run > max_run) max_run = idle_run;
    end
    d_req = 0; f_req = 0;
    total++;
    if (acks.size() != 3 || acks[0] != 3 || acks[1] != 7 || acks[2] != 11) begin
      bad++; $display("FAIL b2b_acks got n=%0d first=%0d want n=3 at 3,7,11", acks.size(), acks.size() > 0 ? acks[0] : -1);
    end
    total++;
    if (max_run > 1 || fcnt != 0) begin
      bad++; $display("FAIL b2b_busy_starve got idle_run=%0d f_acks=%0d want <=1 and 0", max_run, fcnt);
    end
    repeat (2) begin @(posedge clock); @(negedge clock); end
    total++;
    if ({busy, f_ack, d_ack} !== 3'b000) begin
      bad++; $display("FAIL b2b_release got=%b want=000", {busy, f_ack, d_ack});
    end
  endtask

  task automatic test_reset_mid();
    int fa = -1, dcnt = 0;
    @(negedge clock);
    d_we = 0; d_addr = 16'h0010; d_req = 1;
    @(posedge clock); @(negedge clock);
    f_addr = 16'h0003; f_req = 1;
    @(posedge clock); @(negedge clock);
    total++;
    if (mem_read !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got mem_read=%b want=1", mem_read);
    end
    #1 reset = 1;
    #1;
    total++;
    if ({mem_read, mem_write, busy, f_ack, d_ack, mem_addr, d_rdata, f_rdata} !== 53'h0) begin
      bad++; $display("FAIL rstmid_out got=%b/%h/%h/%h want all 0", {mem_read, mem_write, busy, f_ack, d_ack}, mem_addr, d_rdata, f_rdata);
    end
    d_req = 0;
    repeat (2) begin
      @(posedge clock); @(negedge clock);
      if (d_ack === 1'b1) dcnt++;
    end
    reset = 0;
    for (int i = 1; i <= 10 && fa < 0; i++) begin
      @(posedge clock); @(negedge clock);
      if (d_ack === 1'b1) dcnt++;
      if (f_ack === 1'b1) fa = i;
    end
    f_req = 0;
    total++;
    if (fa != 3 || f_rdata !== 16'h1234 || dcnt != 0) begin
      bad++; $display("FAIL rstmid_after got f_ack=%0d data=%h d_acks=%0d want 3/1234/0", fa, f_rdata, dcnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] shadow [256];
    logic [15:0] g_addr = 0, g_wd = 0;
    int  age = 0;
    bit  g_d = 0, g_we = 0, drained = 0;
`ifdef ROUND_ROBIN_EN
    bit  last_d = 0;
`endif
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      shadow[i] = 16'($urandom);
      pre_we = 1; pre_a = 8'(i); pre_d = shadow[i];
    end
    @(negedge clock);
    pre_we = 0;
    for (int cyc = 0; cyc < 800 && !drained; cyc++) begin
      total++;
      if (f_ack !== (age == 3 && !g_d) || d_ack !== (age == 3 && g_d)) begin
        bad++; $display("FAIL rand_ack cyc=%0d got f=%b d=%b want f=%b d=%b", cyc, f_ack, d_ack, age == 3 && !g_d, age == 3 && g_d);
      end
      total++;
      if ({busy, mem_read, mem_write} !== {age != 0, age == 2 && !g_we, age == 2 && g_we}) begin
        bad++; $display("FAIL rand_strobe cyc=%0d got=%b want=%b", cyc, {busy, mem_read, mem_write}, {age != 0, age == 2 && !g_we, age == 2 && g_we});
      end
      if (age != 0) begin
        total++;
        if (mem_addr !== g_addr) begin
          bad++; $display("FAIL rand_addr cyc=%0d got=%h want=%h", cyc, mem_addr, g_addr);
        end
      end
      if (age == 3 && !g_we) begin
        total++;
        if ((g_d ? d_rdata : f_rdata) !== shadow[g_addr[7:0]]) begin
          bad++; $display("FAIL rand_rdata cyc=%0d port=%0d got=%h want=%h", cyc, g_d, g_d ? d_rdata : f_rdata, shadow[g_addr[7:0]]);
        end
      end
      if (age == 3 && g_we) shadow[g_addr[7:0]] = g_wd;
      if (age == 3) begin
        if (g_d) d_req = 0;
        else f_req = 0;
      end
      if (age != 0) begin
        if (g_d) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom); end
        else f_addr = 16'($urandom);
      end
      if (cyc < 600) begin
        if (!f_req && $urandom_range(0, 3) == 0) begin f_req = 1; f_addr = 16'($urandom); end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
      end else drained = !f_req && !d_req && age == 0;
      if (!drained) begin
        @(posedge clock);
        if (age == 0) begin
          if (f_req || d_req) begin
`ifdef ROUND_ROBIN_EN
            g_d = (f_req && d_req) ? !last_d : d_req;
            last_d = g_d;
`else
            g_d = d_req;
`endif
            g_we = g_d && d_we;
            g_addr = g_d ? d_addr : f_addr;
            g_wd = d_wdata;
            age = 1;
          end
        end else age = (age == 3) ? 0 : age + 1;
        @(negedge clock);
      end
    end
    f_req = 0; d_req = 0;
    total++;
    if (!drained) begin
      bad++; $display("FAIL rand_drain got pending traffic after cycle budget want idle");
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
